// File: rtl/hamming_pkg.sv
// Shared definitions for the streaming Hamming decoder: position maps, parity sizing, decode status.
// HAMMING_SECDED_EN widens the codeword by one overall-parity bit.
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
  localparam int SECDED_W = 1;
`else
  localparam int SECDED_W = 0;
`endif

  typedef enum logic [1:0] {
    DEC_CLEAN     = 2'd0,
    DEC_CORRECTED = 2'd1,
    DEC_UNCORR    = 2'd2
  } decodeStatus_t;

  function automatic logic is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Payload bit k lives at the k-th Hamming position that is not a power of two (k=0 -> position 3).
  function automatic int data_pos(input int k);
    int pos;
    int seen;
    pos  = 0;
    seen = 0;
    for (int p = 3; p <= 2 * k + 8; p++) begin
      if (pos == 0 && !is_pow2(p)) begin
        if (seen == k) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

  function automatic int min_par_w(input int dataW);
    int r;
    r = 0;
    for (int c = 1; c < 31; c++) begin
      if (r == 0 && (1 << c) >= dataW + c + 1) r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator: even-parity check over Hamming positions 1..CODE_W.
// With HAMMING_SECDED_EN it also reports the XOR of every codeword bit.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4
) (
  input  logic [DATA_W+PAR_W+SECDED_W-1:0] code,
`ifdef HAMMING_SECDED_EN
  output logic                             overall,
`endif
  output logic [PAR_W-1:0]                 syndrome
);

  localparam int CODE_W = DATA_W + PAR_W;

  // Syndrome bit j covers every position whose index has bit j set.
  always_comb begin
    syndrome = '0;
    for (int j = 0; j < PAR_W; j++) begin
      for (int p = 1; p <= CODE_W; p++) begin
        if (((p >> j) & 1) == 1) syndrome[j] = syndrome[j] ^ code[p-1];
      end
    end
  end

`ifdef HAMMING_SECDED_EN
  assign overall = ^code;
`endif

endmodule

// File: rtl/hamming_stream_decoder.sv
// Two-stage valid/ready Hamming SEC decoder with saturating corrected/uncorrectable counters.
// Define HAMMING_SECDED_EN to add overall parity and double-error detection (SECDED).
module hamming_stream_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W+PAR_W+SECDED_W-1:0] in_code,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [PAR_W-1:0]                 out_syndrome,
  output logic                             out_corrected,
  output logic                             out_uncorr,
  input  logic                             clr_cnt,
  output logic [CNT_W-1:0]                 cnt_corr,
  output logic [CNT_W-1:0]                 cnt_uncorr
);

  localparam int CODE_W = DATA_W + PAR_W;
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W);

  if (PAR_W < min_par_w(DATA_W)) begin : gParCheck
    $error("hamming_stream_decoder: PAR_W too small for DATA_W");
  end

  logic                s1Valid;
  logic [CODE_W-1:0]   s1Code;
  logic [PAR_W-1:0]    s1Syn;
  logic [PAR_W-1:0]    synComb;
  logic                s2Advance;
  logic                deliver;
  logic                synInRange;
  decodeStatus_t       status;
  logic [CODE_W-1:0]   flipMask;
  logic [CODE_W-1:0]   fixedCode;
  logic [DATA_W-1:0]   decData;
`ifdef HAMMING_SECDED_EN
  logic                s1Overall;
  logic                overallComb;
`endif

  assign s2Advance = !out_valid || out_ready;
  assign in_ready  = !s1Valid || s2Advance;
  assign deliver   = out_valid && out_ready;

  hamming_syndrome #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W)
  ) uSyndrome (
    .code     (in_code),
`ifdef HAMMING_SECDED_EN
    .overall  (overallComb),
`endif
    .syndrome (synComb)
  );

  // Stage 1 captures the raw code and its syndrome; it only moves when stage 2 can take its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid   <= 1'b0;
      s1Code    <= '0;
      s1Syn     <= '0;
`ifdef HAMMING_SECDED_EN
      s1Overall <= 1'b0;
`endif
    end else if (in_ready) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Code    <= in_code[CODE_W-1:0];
        s1Syn     <= synComb;
`ifdef HAMMING_SECDED_EN
        s1Overall <= overallComb;
`endif
      end
    end
  end

  // Classify the word, then flip only the position the syndrome names when it is correctable.
  always_comb begin
    synInRange = (s1Syn != '0) && (s1Syn <= MAX_POS);
    status     = DEC_CLEAN;
`ifdef HAMMING_SECDED_EN
    if (s1Syn != '0) begin
      status = (s1Overall && synInRange) ? DEC_CORRECTED : DEC_UNCORR;
    end else if (s1Overall) begin
      status = DEC_CORRECTED;
    end
`else
    if (s1Syn != '0) begin
      status = synInRange ? DEC_CORRECTED : DEC_UNCORR;
    end
`endif
    flipMask = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (status == DEC_CORRECTED && s1Syn == PAR_W'(p)) flipMask[p-1] = 1'b1;
    end
    fixedCode = s1Code ^ flipMask;
  end

  for (genvar k = 0; k < DATA_W; k++) begin : gExtract
    assign decData[k] = fixedCode[data_pos(k)-1];
  end

  // Stage 2 is the output register; it holds everything while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
    end else if (s2Advance) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        out_data      <= decData;
        out_syndrome  <= s1Syn;
        out_corrected <= (status == DEC_CORRECTED);
        out_uncorr    <= (status == DEC_UNCORR);
      end
    end
  end

  // Counters track delivered words only; a clear in the same cycle beats the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (clr_cnt) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (deliver) begin
      if (out_corrected && cnt_corr != '1) cnt_corr <= cnt_corr + CNT_W'(1);
      if (out_uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Scoreboard bench for hamming_stream_decoder: directed vectors, random back-pressured stream,
// counter saturation/clear and mid-stream reset; follows HAMMING_SECDED_EN like the design.
module tb_hamming_stream_decoder;
  import hamming_pkg::*;

  localparam int DATA_W = 8;
  localparam int PAR_W  = 4;
  localparam int CNT_W  = 4;
  localparam int CODE_W = DATA_W + PAR_W;
  localparam int IN_W   = CODE_W + SECDED_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  syn;
    logic              corr;
    logic              uncorr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_corrected;
  logic              out_uncorr;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_uncorr;

  exp_t expQ[$];
  exp_t pendingExp;
  int   nChecks = 0;
  int   nFails  = 0;
  int   modelCorr = 0;
  int   modelUncorr = 0;
  bit   readyRandom = 1'b0;

  hamming_stream_decoder #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected),
    .out_uncorr    (out_uncorr),
    .clr_cnt       (clr_cnt),
    .cnt_corr      (cnt_corr),
    .cnt_uncorr    (cnt_uncorr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference decode: syndrome is the XOR of the indices of all set positions.
  function automatic exp_t refModel(input logic [IN_W-1:0] code);
    exp_t            e;
    int              syn;
    int              flipPos;
    int              k;
    logic [IN_W-1:0] fixed;
`ifdef HAMMING_SECDED_EN
    logic            odd;
`endif
    syn     = 0;
    flipPos = 0;
    k       = 0;
    for (int p = 1; p <= CODE_W; p++) if (code[p-1]) syn = syn ^ p;
    e.corr   = 1'b0;
    e.uncorr = 1'b0;
`ifdef HAMMING_SECDED_EN
    odd = ^code;
    if (syn == 0) e.corr = odd;
    else if (odd && syn <= CODE_W) begin e.corr = 1'b1; flipPos = syn; end
    else e.uncorr = 1'b1;
`else
    if (syn != 0 && syn <= CODE_W) begin e.corr = 1'b1; flipPos = syn; end
    else if (syn != 0) e.uncorr = 1'b1;
`endif
    fixed = code;
    if (flipPos != 0) fixed[flipPos-1] = ~fixed[flipPos-1];
    e.data = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if ($countones(p) != 1) begin e.data[k] = fixed[p-1]; k++; end
    end
    e.syn = PAR_W'(syn);
    return e;
  endfunction

  function automatic logic [IN_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [IN_W-1:0] code;
    int              syn;
    int              k;
    code = '0;
    syn  = 0;
    k    = 0;
    for (int p = 1; p <= CODE_W; p++) begin
      if ($countones(p) != 1) begin code[p-1] = d[k]; k++; end
    end
    for (int p = 1; p <= CODE_W; p++) if (code[p-1]) syn = syn ^ p;
    for (int j = 0; j < PAR_W; j++) code[(1 << j) - 1] = ((syn >> j) & 1) == 1;
`ifdef HAMMING_SECDED_EN
    code[CODE_W] = ^code[CODE_W-1:0];
`endif
    return code;
  endfunction

  function automatic logic [IN_W-1:0] randomWord(input int forceErrs);
    logic [IN_W-1:0] code;
    int              nErr;
    int              a;
    int              b;
    code = encode(DATA_W'($urandom));
    nErr = (forceErrs >= 0) ? forceErrs : int'($urandom_range(0, 3));
    a = int'($urandom_range(0, IN_W - 1));
    b = (a + 1 + int'($urandom_range(0, IN_W - 2))) % IN_W;
    if (nErr >= 1) code[a] = ~code[a];
    if (nErr == 2) code[b] = ~code[b];
    if (nErr == 3) code = IN_W'($urandom);
    return code;
  endfunction

  task automatic applyStimulus(input logic [IN_W-1:0] code, input exp_t e);
    bit accepted;
    accepted   = 1'b0;
    in_code    = code;
    pendingExp = e;
    in_valid   = 1'b1;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("inAccepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 300 && expQ.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, owns the expected queue and counter model.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      modelCorr   = 0;
      modelUncorr = 0;
      checkOutput("rstOutValid", 32'(out_valid), 32'd0);
      checkOutput("rstOutData", 32'(out_data), 32'd0);
      checkOutput("rstOutSyn", 32'(out_syndrome), 32'd0);
      checkOutput("rstFlags", 32'({out_corrected, out_uncorr}), 32'd0);
      checkOutput("rstCntCorr", 32'(cnt_corr), 32'(modelCorr));
      checkOutput("rstCntUncorr", 32'(cnt_uncorr), 32'(modelUncorr));
    end else begin
      checkOutput("cntCorr", 32'(cnt_corr), 32'(modelCorr));
      checkOutput("cntUncorr", 32'(cnt_uncorr), 32'(modelUncorr));
      checkOutput("inReady", 32'(in_ready), 32'(!(expQ.size() == 2 && !out_ready)));
      if (out_valid && expQ.size() == 0) begin
        checkOutput("spuriousOutValid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        checkOutput("outData", 32'(out_data), 32'(expQ[0].data));
        checkOutput("outSyndrome", 32'(out_syndrome), 32'(expQ[0].syn));
        checkOutput("outCorrected", 32'(out_corrected), 32'(expQ[0].corr));
        checkOutput("outUncorr", 32'(out_uncorr), 32'(expQ[0].uncorr));
        if (out_ready) begin
          if (!clr_cnt) begin
            if (expQ[0].corr && modelCorr < (1 << CNT_W) - 1) modelCorr++;
            if (expQ[0].uncorr && modelUncorr < (1 << CNT_W) - 1) modelUncorr++;
          end
          void'(expQ.pop_front());
        end
      end
      if (clr_cnt) begin
        modelCorr   = 0;
        modelUncorr = 0;
      end
      if (in_valid && in_ready) expQ.push_back(pendingExp);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    nFails++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [IN_W-1:0] dirCode[4];
  exp_t            dirExp[4];
  int              nDir;
  logic [IN_W-1:0] code;

  initial begin
    in_valid = 1'b0;
    in_code  = '0;
    clr_cnt  = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef HAMMING_SECDED_EN
    nDir = 4;
    dirCode[0] = 13'h1A0D; dirExp[0] = '{data: 8'hA1, syn: 4'd0, corr: 1'b0, uncorr: 1'b0};
    dirCode[1] = 13'h1A0E; dirExp[1] = '{data: 8'hA1, syn: 4'd3, corr: 1'b0, uncorr: 1'b1};
    dirCode[2] = 13'h1B0D; dirExp[2] = '{data: 8'hA1, syn: 4'd9, corr: 1'b1, uncorr: 1'b0};
    dirCode[3] = 13'h0A0D; dirExp[3] = '{data: 8'hA1, syn: 4'd0, corr: 1'b1, uncorr: 1'b0};
`else
    nDir = 3;
    dirCode[0] = 12'hA0D; dirExp[0] = '{data: 8'hA1, syn: 4'd0, corr: 1'b0, uncorr: 1'b0};
    dirCode[1] = 12'hB0D; dirExp[1] = '{data: 8'hA1, syn: 4'd9, corr: 1'b1, uncorr: 1'b0};
    dirCode[2] = 12'h209; dirExp[2] = '{data: 8'h20, syn: 4'd15, corr: 1'b0, uncorr: 1'b1};
    dirCode[3] = '0;      dirExp[3] = dirExp[0];
`endif

    applyStimulus(dirCode[0], dirExp[0]);
    @(negedge clk);
    checkOutput("latencyCycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latencyCycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 1; i < nDir; i++) applyStimulus(dirCode[i], dirExp[i]);
    waitDrain();
`ifdef HAMMING_SECDED_EN
    checkOutput("dirCntCorr", 32'(cnt_corr), 32'd2);
`else
    checkOutput("dirCntCorr", 32'(cnt_corr), 32'd1);
`endif
    checkOutput("dirCntUncorr", 32'(cnt_uncorr), 32'd1);

    $display("[TB] random back-pressured stream");
    readyRandom = 1'b1;
    for (int i = 0; i < 48; i++) begin
      code = randomWord(-1);
      applyStimulus(code, refModel(code));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    waitDrain();
    readyRandom = 1'b0;

    $display("[TB] counter saturation and clear");
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      code = randomWord(1);
      applyStimulus(code, refModel(code));
    end
    waitDrain();
    checkOutput("cntCorrSaturated", 32'(cnt_corr), 32'hF);
    code = randomWord(1);
    applyStimulus(code, refModel(code));
    @(posedge clk);
    #1 clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    @(negedge clk);
    checkOutput("clrWordDelivered", 32'(expQ.size()), 32'd0);
    checkOutput("cntClearWins", 32'(cnt_corr), 32'd0);

    $display("[TB] mid-stream reset");
    readyRandom = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      code = randomWord(-1);
      applyStimulus(code, refModel(code));
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstCounters", 32'({cnt_corr, cnt_uncorr}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    readyRandom = 1'b0;
    for (int i = 0; i < 6; i++) begin
      code = randomWord(-1);
      applyStimulus(code, refModel(code));
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
